wb_write_scheduler: RTL and testbench

- Schedules register-file writes from the write-back stage onto the two RF write ports.
- Each dual-issue group can carry up to three writes: inst0 primary, inst0 secondary (UMULL/SMULL high), inst1 primary. The block never drops one; the overflow goes into an in-order FIFO and back-pressures upstream.
- Sits between the MEM/WB register / write-back stage and the register file.
- Also provides pending-write lookup for forwarding and a drain-before-halt sequencer.

---
 rtl/wb_write_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_wb_write_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_scheduler.sv
// wb_write_scheduler
//   Schedules write-back register-file writes onto two registered RF write
//   ports. A group carries up to three writes (inst0 rd, inst0 rd2, inst1 rd);
//   writes that do not fit are queued in an in-order overflow FIFO and
//   upstream is back-pressured. Also answers pending-write lookups for
//   forwarding and sequences a drain before halting.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        group handshake (in_ready from registered state)
//   in_halt                  group contains a halt
//   req_we/req_addr/req_data per-slot write enables, 3x4b addresses, 3x16b data
//   rf_wr_en/addr/data_0/1   registered RF ports (port 1 is the younger write)
//   lookup_addr/hit/data     youngest pending write for lookup_addr
//   idle                     FIFO empty and no port write in flight
//   halted                   halt reached and every write drained
module wb_write_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_halt,
  input  logic [2:0]  req_we,
  input  logic [11:0] req_addr,
  input  logic [47:0] req_data,
  output logic        rf_wr_en_0,
  output logic [3:0]  rf_wr_addr_0,
  output logic [15:0] rf_wr_data_0,
  output logic        rf_wr_en_1,
  output logic [3:0]  rf_wr_addr_1,
  output logic [15:0] rf_wr_data_1,
  input  logic [3:0]  lookup_addr,
  output logic        lookup_hit,
  output logic [15:0] lookup_data,
  output logic        idle,
  output logic        halted
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]    r_fifo_addr [DEPTH];
  logic [15:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [CW-1:0] r_count;
  logic          r_en0, r_en1;
  logic [3:0]    r_addr0, r_addr1;
  logic [15:0]   r_data0, r_data1;

  logic          w_acc;
  logic [3:0]    w_s_addr [3];
  logic [15:0]   w_s_data [3];
  logic [3:0]    w_g_addr [3];
  logic [15:0]   w_g_data [3];
  logic [1:0]    w_ng;
  int unsigned   w_ngi, w_cnt, w_npop, w_gskip, w_cnt_nxt;
  logic          w_c0_vld, w_c1_vld, w_p0_en;
  logic [3:0]    w_c0_addr, w_c1_addr;
  logic [15:0]   w_c0_data, w_c1_data;
  logic [2:0]    w_push;
  logic [PW-1:0] w_push_idx [3];
  logic [PW-1:0] w_lk_idx;

  // Operands never exceed 2*DEPTH, so two conditional subtractions suffice.
  function automatic logic [PW-1:0] wrap(input int unsigned x);
    int unsigned y;
    y = x;
    if (y >= DEPTH) y = y - DEPTH;
    if (y >= DEPTH) y = y - DEPTH;
    return PW'(y);
  endfunction

  assign w_s_addr[0] = req_addr[3:0];
  assign w_s_addr[1] = req_addr[7:4];
  assign w_s_addr[2] = req_addr[11:8];
  assign w_s_data[0] = req_data[15:0];
  assign w_s_data[1] = req_data[31:16];
  assign w_s_data[2] = req_data[47:32];

  assign in_ready = (r_state == S_RUN) && (32'(r_count) <= DEPTH - 1);
  assign w_acc    = in_valid && in_ready;
  assign idle     = (r_count == '0) && !r_en0 && !r_en1;
  assign halted   = (r_state == S_HALTED);

  assign rf_wr_en_0   = r_en0;
  assign rf_wr_addr_0 = r_addr0;
  assign rf_wr_data_0 = r_data0;
  assign rf_wr_en_1   = r_en1;
  assign rf_wr_addr_1 = r_addr1;
  assign rf_wr_data_1 = r_data1;

  // Candidate ordering: FIFO head entries first, then the accepted group's
  // enabled slots compacted in program order.
  always_comb begin
    w_cnt = 32'(r_count);
    w_npop = (w_cnt >= 2) ? 2 : w_cnt;
    w_gskip = 2 - w_npop;
    w_ng = 2'd0;
    for (int unsigned j = 0; j < 3; j++) begin
      w_g_addr[2'(j)] = '0;
      w_g_data[2'(j)] = '0;
    end
    for (int unsigned s = 0; s < 3; s++) begin
      if (w_acc && req_we[2'(s)]) begin
        w_g_addr[w_ng] = w_s_addr[2'(s)];
        w_g_data[w_ng] = w_s_data[2'(s)];
        w_ng = w_ng + 2'd1;
      end
    end
    w_ngi = 32'(w_ng);

    w_c0_vld = 1'b0;
    w_c0_addr = '0;
    w_c0_data = '0;
    if (w_npop >= 1) begin
      w_c0_vld = 1'b1;
      w_c0_addr = r_fifo_addr[r_head];
      w_c0_data = r_fifo_data[r_head];
    end else if (w_ngi >= 1) begin
      w_c0_vld = 1'b1;
      w_c0_addr = w_g_addr[0];
      w_c0_data = w_g_data[0];
    end

    w_c1_vld = 1'b0;
    w_c1_addr = '0;
    w_c1_data = '0;
    if (w_npop == 2) begin
      w_c1_vld = 1'b1;
      w_c1_addr = r_fifo_addr[wrap(32'(r_head) + 1)];
      w_c1_data = r_fifo_data[wrap(32'(r_head) + 1)];
    end else if (w_ngi > 1 - w_npop) begin
      w_c1_vld = 1'b1;
      w_c1_addr = w_g_addr[2'(1 - w_npop)];
      w_c1_data = w_g_data[2'(1 - w_npop)];
    end

    // Same-address pair: only the younger write (port 1) is performed.
    w_p0_en = w_c0_vld && !(w_c1_vld && (w_c0_addr == w_c1_addr));

    // Group slots past the two issued candidates go to the tail. Fewer than
    // two pops means the FIFO empties this cycle, so order is preserved.
    for (int unsigned j = 0; j < 3; j++) begin
      w_push[2'(j)] = (j >= w_gskip) && (j < w_ngi);
      w_push_idx[2'(j)] = wrap(32'(r_head) + w_cnt + j - w_gskip);
    end

    w_cnt_nxt = (w_cnt + w_ngi > 2) ? (w_cnt + w_ngi - 2) : 0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_acc && in_halt) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((w_cnt == 0) && !w_c0_vld) w_state_nxt = S_HALTED;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_count <= '0;
      r_en0   <= 1'b0;
      r_addr0 <= '0;
      r_data0 <= '0;
      r_en1   <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      r_head  <= wrap(32'(r_head) + w_npop);
      r_count <= CW'(w_cnt_nxt);
      r_en0   <= w_p0_en;
      r_addr0 <= w_p0_en ? w_c0_addr : '0;
      r_data0 <= w_p0_en ? w_c0_data : '0;
      r_en1   <= w_c1_vld;
      r_addr1 <= w_c1_addr;
      r_data1 <= w_c1_data;
      for (int unsigned j = 0; j < 3; j++) begin
        if (w_push[2'(j)]) begin
          r_fifo_addr[w_push_idx[2'(j)]] <= w_g_addr[2'(j)];
          r_fifo_data[w_push_idx[2'(j)]] <= w_g_data[2'(j)];
        end
      end
    end
  end

  // Age order: port 0, port 1, then FIFO head to tail; later matches win.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_data = '0;
    w_lk_idx = '0;
    if (r_en0 && (r_addr0 == lookup_addr)) begin
      lookup_hit = 1'b1;
      lookup_data = r_data0;
    end
    if (r_en1 && (r_addr1 == lookup_addr)) begin
      lookup_hit = 1'b1;
      lookup_data = r_data1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < w_cnt) begin
        w_lk_idx = wrap(32'(r_head) + i);
        if (r_fifo_addr[w_lk_idx] == lookup_addr) begin
          lookup_hit = 1'b1;
          lookup_data = r_fifo_data[w_lk_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Testbench for wb_write_scheduler: table-driven single-group vectors plus
// hand-written multi-cycle sequences, with an in-order write scoreboard.
module tb_wb_write_scheduler;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_halt;
  logic [2:0]  req_we;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic        rf_wr_en_0, rf_wr_en_1;
  logic [3:0]  rf_wr_addr_0, rf_wr_addr_1;
  logic [15:0] rf_wr_data_0, rf_wr_data_1;
  logic [3:0]  lookup_addr;
  logic        lookup_hit;
  logic [15:0] lookup_data;
  logic        idle;
  logic        halted;

  always #5 clk = ~clk;

  wb_write_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_halt(in_halt), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .rf_wr_en_0(rf_wr_en_0), .rf_wr_addr_0(rf_wr_addr_0), .rf_wr_data_0(rf_wr_data_0),
    .rf_wr_en_1(rf_wr_en_1), .rf_wr_addr_1(rf_wr_addr_1), .rf_wr_data_1(rf_wr_data_1),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .idle(idle), .halted(halted)
  );

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [2:0]  we;
    logic [11:0] addr;
    logic [47:0] data;
    logic [3:0]  lk;
    logic        e1_en0;
    logic [3:0]  e1_a0;
    logic [15:0] e1_d0;
    logic        e1_en1;
    logic [3:0]  e1_a1;
    logic [15:0] e1_d1;
    logic        e1_hit;
    logic [15:0] e1_ld;
    logic        e2_en0;
    logic [3:0]  e2_a0;
    logic [15:0] e2_d0;
    logic        e2_en1;
    logic        e2_idle;
  } vec_t;

  wr_t         sbq[$];
  logic [15:0] exp_rf [16];
  logic [15:0] dut_rf [16];
  vec_t        vecs [8];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic sb_check(input logic [3:0] a, input logic [15:0] d, input string nm);
    wr_t f;
    if (sbq.size() == 0) fail({nm, "_unexpected_write"});
    else begin
      f = sbq.pop_front();
      chk({nm, "_addr"}, 32'(a), 32'(f.a));
      chk({nm, "_data"}, 32'(d), 32'(f.d));
    end
    dut_rf[a] = d;
  endtask

  // A lone port-1 write means the older write of the pair was suppressed;
  // it must target the same register.
  always @(negedge clk) begin : mon
    wr_t f;
    if (rf_wr_en_0 || rf_wr_en_1) begin
      if (!rf_wr_en_0) begin
        if (sbq.size() == 0) fail("sb_suppressed_underflow");
        else begin
          f = sbq.pop_front();
          chk("sb_suppressed_addr", 32'(rf_wr_addr_1), 32'(f.a));
        end
      end
      if (rf_wr_en_0) sb_check(rf_wr_addr_0, rf_wr_data_0, "port0");
      if (rf_wr_en_1) sb_check(rf_wr_addr_1, rf_wr_data_1, "port1");
    end
  end

  task automatic push_group(input logic [2:0] we, input logic [11:0] addr, input logic [47:0] data);
    wr_t w;
    for (int s = 0; s < 3; s++) begin
      if (we[s]) begin
        w.a = addr[4*s +: 4];
        w.d = data[16*s +: 16];
        sbq.push_back(w);
        exp_rf[w.a] = w.d;
      end
    end
  endtask

  task automatic send(input logic [2:0] we, input logic [11:0] addr, input logic [47:0] data,
                      input logic halt, input logic exp_acc, input string nm);
    in_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_data = data;
    in_halt = halt;
    chk({nm, "_ready"}, 32'(in_ready), 32'(exp_acc));
    if (exp_acc) push_group(we, addr, data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    req_we = '0;
    in_halt = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n;
    n = 0;
    while (!idle && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!idle) fail({nm, "_idle_timeout"});
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_idle(p);
    lookup_addr = v.lk;
    send(v.we, v.addr, v.data, 1'b0, 1'b1, p);
    chk({p, "_c1_en0"},  32'(rf_wr_en_0),   32'(v.e1_en0));
    chk({p, "_c1_a0"},   32'(rf_wr_addr_0), 32'(v.e1_a0));
    chk({p, "_c1_d0"},   32'(rf_wr_data_0), 32'(v.e1_d0));
    chk({p, "_c1_en1"},  32'(rf_wr_en_1),   32'(v.e1_en1));
    chk({p, "_c1_a1"},   32'(rf_wr_addr_1), 32'(v.e1_a1));
    chk({p, "_c1_d1"},   32'(rf_wr_data_1), 32'(v.e1_d1));
    chk({p, "_lk_hit"},  32'(lookup_hit),   32'(v.e1_hit));
    chk({p, "_lk_data"}, 32'(lookup_data),  32'(v.e1_ld));
    @(posedge clk); #1;
    chk({p, "_c2_en0"},  32'(rf_wr_en_0),   32'(v.e2_en0));
    chk({p, "_c2_a0"},   32'(rf_wr_addr_0), 32'(v.e2_a0));
    chk({p, "_c2_d0"},   32'(rf_wr_data_0), 32'(v.e2_d0));
    chk({p, "_c2_en1"},  32'(rf_wr_en_1),   32'(v.e2_en1));
    chk({p, "_c2_idle"}, 32'(idle),         32'(v.e2_idle));
  endtask

  task automatic check_reset_state(input string p);
    chk({p, "_en0"},    32'(rf_wr_en_0),   32'd0);
    chk({p, "_en1"},    32'(rf_wr_en_1),   32'd0);
    chk({p, "_addr0"},  32'(rf_wr_addr_0), 32'd0);
    chk({p, "_data1"},  32'(rf_wr_data_1), 32'd0);
    chk({p, "_idle"},   32'(idle),         32'd1);
    chk({p, "_halted"}, 32'(halted),       32'd0);
    chk({p, "_ready"},  32'(in_ready),     32'd1);
    chk({p, "_lk_hit"}, 32'(lookup_hit),   32'd0);
  endtask

  // Back-to-back three-write groups fill the FIFO to DEPTH.
  task automatic test_fill();
    logic [11:0] a;
    logic [47:0] d;
    wait_idle("t3");
    for (int g = 0; g < 4; g++) begin
      a = {4'(10 + (g + 2) % 4), 4'(10 + (g + 1) % 4), 4'(10 + g % 4)};
      d = {16'(16'h3002 + g * 16), 16'(16'h3001 + g * 16), 16'(16'h3000 + g * 16)};
      send(3'b111, a, d, 1'b0, 1'b1, $sformatf("t3_g%0d", g));
    end
    chk("t3_full_busy", 32'(idle), 32'd0);
    send(3'b111, 12'hFFF, {3{16'hDEAD}}, 1'b0, 1'b0, "t3_full");
    chk("t3_ready_after_drain2", 32'(in_ready), 32'd1);
    wait_idle("t3");
    for (int r = 10; r < 14; r++)
      chk($sformatf("t3_rf%0d", r), 32'(dut_rf[r]), 32'(exp_rf[r]));
  endtask

  // Halt group arrives while the FIFO holds two entries.
  task automatic test_halt();
    logic saw, done;
    wait_idle("t5");
    send(3'b111, 12'h321, 48'h5003_5002_5001, 1'b0, 1'b1, "t5_a");
    send(3'b111, 12'h654, 48'h5006_5005_5004, 1'b0, 1'b1, "t5_b");
    send(3'b011, 12'h087, 48'h0000_5008_5007, 1'b1, 1'b1, "t5_halt");
    in_valid = 1'b1;
    req_we = 3'b111;
    req_addr = 12'hFFF;
    req_data = {3{16'hBAD0}};
    chk("t5_ready_drain", 32'(in_ready), 32'd0);
    saw = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (rf_wr_en_0 || rf_wr_en_1) begin
        chk("t5_halted_during_drain", 32'(halted), 32'd0);
        saw = 1'b1;
      end else if (saw) begin
        chk("t5_halted_after_drain", 32'(halted), 32'd1);
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) fail("t5_halt_timeout");
    for (int c = 0; c < 4; c++) begin
      chk("t5_halted_hold", 32'(halted), 32'd1);
      chk("t5_ready_halted", 32'(in_ready), 32'd0);
      chk("t5_idle_halted", 32'(idle), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    req_we = '0;
  endtask

  // Reset while draining with three entries queued.
  task automatic test_reset_drain();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("t6_ready_after_rst", 32'(in_ready), 32'd1);
    send(3'b111, 12'h321, 48'h6003_6002_6001, 1'b0, 1'b1, "t6_a");
    send(3'b111, 12'h654, 48'h6006_6005_6004, 1'b0, 1'b1, "t6_b");
    send(3'b111, 12'h987, 48'h6009_6008_6007, 1'b1, 1'b1, "t6_halt");
    chk("t6_drain_ready", 32'(in_ready), 32'd0);
    chk("t6_drain_busy", 32'(idle), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    check_reset_state("t6_rst");
    rst = 1'b0;
    apply_vec(vecs[0], 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 16; r++) begin
      exp_rf[r] = '0;
      dut_rf[r] = '0;
    end
    //          we      addr     data                    lk     en0   a0    d0        en1   a1    d1        hit   ldata     en0   a0    d0        en1   idle
    vecs[0] = '{3'b101, 12'h201, 48'h2222_0000_1111, 4'h2, 1'b1, 4'h1, 16'h1111, 1'b1, 4'h2, 16'h2222, 1'b1, 16'h2222, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[1] = '{3'b111, 12'h543, 48'h000C_000B_000A, 4'h5, 1'b1, 4'h3, 16'h000A, 1'b1, 4'h4, 16'h000B, 1'b1, 16'h000C, 1'b1, 4'h5, 16'h000C, 1'b0, 1'b0};
    vecs[2] = '{3'b101, 12'h606, 48'h0002_0000_0001, 4'h6, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h6, 16'h0002, 1'b1, 16'h0002, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{3'b111, 12'h777, 48'h0073_0072_0071, 4'h7, 1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h0072, 1'b1, 16'h0073, 1'b1, 4'h7, 16'h0073, 1'b0, 1'b0};
    vecs[4] = '{3'b000, 12'h321, 48'h3333_2222_1111, 4'h1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{3'b010, 12'h90F, 48'h1234_BEEF_5678, 4'h0, 1'b1, 4'h0, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{3'b110, 12'h981, 48'h9999_8888_1111, 4'h9, 1'b1, 4'h8, 16'h8888, 1'b1, 4'h9, 16'h9999, 1'b1, 16'h9999, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{3'b111, 12'hABA, 48'h00A2_00B1_00A1, 4'hA, 1'b1, 4'hA, 16'h00A1, 1'b1, 4'hB, 16'h00B1, 1'b1, 16'h00A2, 1'b1, 4'hA, 16'h00A2, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_halt = 1'b0;
    req_we = '0;
    req_addr = '0;
    req_data = '0;
    lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    test_fill();
    test_halt();
    test_reset_drain();

    wait_idle("final");
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
